// File: rtl/nibble_rx_fifo.sv
// Strobe/acknowledge nibble receiver feeding a small first-word-fall-through FIFO.
// The head nibble drives the zero-extension buffer on the core I/O read path.
module nibble_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [3:0]    EXT_D,
    input  logic          EXT_STB,
    output logic          EXT_ACK,
    input  logic          RD_EN,
    output logic [3:0]    DOUT,
    output logic          DVALID,
    output logic          FULL,
    output logic [CW-1:0] COUNT
);
    // state    | meaning
    // WAIT_LOW | after reset; ignore strobe until it is seen low
    // IDLE     | ready; accept nibble when strobe high and space exists
    // ACK      | nibble taken, EXT_ACK high until strobe drops
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        ACK      = 2'd2
    } state_t;

    state_t        state;
    logic          stb_meta;
    logic          stb_s;
    logic [1:0]    settle;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    mem [DEPTH];
    logic          pop;
    logic          space;
    logic          push;

    assign DVALID = (COUNT != '0);
    assign FULL   = (COUNT == CW'(DEPTH));
    assign pop    = RD_EN && DVALID;
    assign space  = !FULL || pop;
    assign push   = (state == IDLE) && stb_s && space;
    assign DOUT   = DVALID ? mem[rd_ptr] : 4'h0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stb_meta <= 1'b0;
            stb_s    <= 1'b0;
        end else begin
            stb_meta <= EXT_STB;
            stb_s    <= stb_meta;
        end
    end

    // stb_s reads 0 straight out of reset regardless of the pin; hold
    // WAIT_LOW until the synchroniser has been refilled from EXT_STB.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle <= 2'd2;
        end else if (settle != 2'd0) begin
            settle <= settle - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= WAIT_LOW;
            EXT_ACK <= 1'b0;
        end else begin
            case (state)
                WAIT_LOW: begin
                    EXT_ACK <= 1'b0;
                    if (settle == 2'd0 && !stb_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (push) begin
                        state   <= ACK;
                        EXT_ACK <= 1'b1;
                    end else begin
                        EXT_ACK <= 1'b0;
                    end
                end
                ACK: begin
                    if (!stb_s) begin
                        state   <= IDLE;
                        EXT_ACK <= 1'b0;
                    end else begin
                        EXT_ACK <= 1'b1;
                    end
                end
                default: begin
                    state   <= WAIT_LOW;
                    EXT_ACK <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   COUNT <= COUNT + CW'(1);
                2'b01:   COUNT <= COUNT - CW'(1);
                default: COUNT <= COUNT;
            endcase
        end
    end

    // Storage needs no reset: DOUT is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= EXT_D;
        end
    end

endmodule

// File: doc/nibble_rx_fifo.md
Name: nibble_rx_fifo

Overview:
- Receives 4-bit nibbles from the external 4-bit I/O bus using an asynchronous four-phase strobe/acknowledge handshake.
- Synchronises the strobe into the core clock domain and buffers the nibbles in a small first-word-fall-through FIFO.
- Presents the head nibble on DOUT. DOUT feeds the 4-to-16 zero-extension buffer that drives the DLX I/O read data path.
- Sits directly upstream of that buffer, between the board I/O pins and the core.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of two, ≥2.
- CW, 3, width of COUNT. Equals log2(DEPTH)+1.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EXT_D  input  4  external nibble data. Must be stable from before EXT_STB rises until EXT_ACK is seen high.
- EXT_STB  input  1  external strobe. Asynchronous to CLK.
- EXT_ACK  output  1  acknowledge to the external device. Registered.
- RD_EN  input  1  core pops the head entry this cycle.
- DOUT  output  4  head nibble. Zero when the FIFO is empty.
- DVALID  output  1  FIFO is non-empty.
- FULL  output  1  FIFO holds DEPTH entries.
- COUNT  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO is emptied: pointers, COUNT, DVALID and FULL all 0.
  - DOUT = 0, EXT_ACK = 0.
  - Both synchroniser flops = 0.
  - FSM enters WAIT_LOW.
- Strobe synchroniser: EXT_STB passes through 2 flops; the output is stb_s. EXT_D is not synchronised. It is sampled directly on the write edge, which is safe under the stability rule above.
- FSM (3 states):
  - WAIT_LOW: EXT_ACK = 0. Go to IDLE when stb_s = 0. This state prevents a strobe still held high across reset from being accepted as a new nibble.
  - IDLE: EXT_ACK = 0. If stb_s = 1 and space is available, write EXT_D into the tail and go to ACK. If stb_s = 1 and no space is available, stay in IDLE (stall). No data is lost and no ACK is issued.
  - ACK: EXT_ACK = 1. Go to IDLE when stb_s = 0. EXT_ACK falls on that same edge.
- Space available = (FULL = 0) OR (RD_EN = 1 AND DVALID = 1) in the same cycle. A simultaneous pop frees the slot.
- Latency:
  - EXT_STB is first sampled high at edge n.
  - stb_s = 1 after edge n+1.
  - Write occurs at edge n+2. DVALID and EXT_ACK are high after edge n+2 (assuming the FIFO was empty and the FSM was in IDLE).
- Read side (first-word-fall-through):
  - DOUT shows the head entry combinationally from storage while DVALID = 1.
  - RD_EN with DVALID = 1 advances the head at the edge.
  - RD_EN with DVALID = 0 is ignored: no pointer change, no error.
- Simultaneous write and pop:
  - COUNT is unchanged.
  - If COUNT was 1, DOUT shows the newly written nibble after the edge.
  - If the FIFO was empty, only the write takes effect, because the pop is ignored.
- Pointers: log2(DEPTH) bits wide, wrapping modulo DEPTH. FULL and DVALID are derived from COUNT: FULL = (COUNT == DEPTH), DVALID = (COUNT != 0).
- Reset mid-handshake (FSM in ACK, STB still high):
  - EXT_ACK drops immediately.
  - Buffered data is discarded.
  - The FSM waits in WAIT_LOW until STB is low, then resumes.

Test Plan:
- Reset then single transfer: hold RST_N low 3 cycles; drive EXT_D=4'hA, raise EXT_STB → DVALID=1, DOUT=4'hA, EXT_ACK=1 at edge 3 after STB is sampled; drop STB → EXT_ACK=0 two edges later; RD_EN for 1 cycle → DVALID=0, DOUT=0, COUNT=0.
- Fill and stall: send 1,2,3,4 with no reads → FULL=1, COUNT=4; fifth nibble 5 with STB high → EXT_ACK stays 0; one RD_EN pulse → nibble 5 is accepted on the same edge as the pop, COUNT stays 4, DOUT=2.
- Wrap-around: push/pop 10 nibbles 0..9 interleaved → DOUT order is 0..9 exactly; COUNT never exceeds 2.
- Simultaneous write and pop at COUNT=1 (head=7, incoming 8) → COUNT=1, DOUT=8 after the edge.
- Empty read: RD_EN=1 for 3 cycles with the FIFO empty → COUNT=0, DVALID=0, DOUT=0.
- Reset mid-handshake: assert RST_N low while in ACK with STB high and COUNT=2 → EXT_ACK=0 and COUNT=0 immediately; release reset with STB still high → no write occurs; drop STB, then send 4'hC → COUNT=1, DOUT=4'hC.
